alu_step_sequencer: RTL and testbench

- Parametrised micro-step controller that drives the register-file and ALU control strobes for one register-to-register ALU instruction: Rd <- Ra op Rb, or HI/LO <- Ra op Rb for MUL/DIV.
- Replaces hand-timed T-state strobing of the DataPath with a reusable FSM.
- Adds unary ops, a multi-cycle ALU ready handshake, a wait timeout and error signalling.
- Sits between the instruction decoder and the DataPath control inputs.

---
 rtl/alu_seq_pkg.sv | 44 ++++
 rtl/alu_step_sequencer_onehot_dec.sv | 18 +
 rtl/alu_step_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_step_sequencer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer states and opcode classifiers
// for the ALU micro-step sequencer.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        EXEC,
        WAIT,
        WB_LO,
        WB_HI
    } state_t;

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_valid(input logic [4:0] op);
        return op inside {
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT
        };
    endfunction

endpackage

// File: rtl/alu_step_sequencer_onehot_dec.sv
// Register index to one-hot strobe decoder with enable;
// indices past N decode to all-zero.
module onehot_dec #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// Micro-step FSM driving register-file and ALU strobes for one
// register-to-register ALU instruction, with multi-cycle wait.
module alu_step_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int OP_W     = 5,
    parameter int WAIT_MAX = 64
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [IDX_W-1:0]    ra_idx,
    input  logic [IDX_W-1:0]    rb_idx,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic                alu_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                ry_in,
    output logic                ry_out,
    output logic                rz_in,
    output logic                rzlo_out,
    output logic                rzhi_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [OP_W-1:0]     alu_op
);

    localparam int CNT_W = 10;

    state_t             state;
    state_t             state_nx;
    logic [OP_W-1:0]    op_q;
    logic [IDX_W-1:0]   ra_q;
    logic [IDX_W-1:0]   rb_q;
    logic [IDX_W-1:0]   rd_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_q;
    logic               req_ok;
    logic               md_q;
    logic               timeout;
    logic               rs_en;
    logic [IDX_W-1:0]   rs_sel;
    logic               wr_en;

    function automatic logic idx_ok(input logic [IDX_W-1:0] i);
        return int'(i) < NUM_REGS;
    endfunction

    assign req_ok = is_valid(5'(op)) && idx_ok(ra_idx)
                    && idx_ok(rb_idx) && idx_ok(rd_idx);
    assign md_q = is_muldiv(5'(op_q));
    // Ready in the last allowed cycle still counts as success.
    assign timeout = (state == WAIT) && !alu_ready
                     && (wait_cnt == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state == IDLE && start) begin
                op_q  <= op;
                ra_q  <= ra_idx;
                rb_q  <= rb_idx;
                rd_q  <= rd_idx;
                err_q <= !req_ok;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && req_ok) begin
                    state_nx = is_unary(5'(op)) ? EXEC : LOAD_A;
                end
            end
            LOAD_A: state_nx = EXEC;
            EXEC:   state_nx = md_q ? WAIT : WB_LO;
            WAIT: begin
                if (alu_ready) begin
                    state_nx = WB_LO;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            WB_LO:   state_nx = md_q ? WB_HI : IDLE;
            WB_HI:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rs_en    = 1'b0;
        rs_sel   = rb_q;
        wr_en    = 1'b0;
        ry_in    = 1'b0;
        ry_out   = 1'b0;
        rz_in    = 1'b0;
        rzlo_out = 1'b0;
        rzhi_out = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        done     = 1'b0;
        alu_op   = '0;
        unique case (state)
            LOAD_A: begin
                rs_en  = 1'b1;
                rs_sel = ra_q;
                ry_in  = 1'b1;
            end
            EXEC: begin
                rs_en  = 1'b1;
                ry_out = 1'b1;
                alu_op = op_q;
                rz_in  = !md_q;
            end
            WAIT: begin
                rs_en  = 1'b1;
                ry_out = 1'b1;
                alu_op = op_q;
                rz_in  = alu_ready;
            end
            WB_LO: begin
                rzlo_out = 1'b1;
                lo_in    = md_q;
                wr_en    = !md_q;
                done     = !md_q;
            end
            WB_HI: begin
                rzhi_out = 1'b1;
                hi_in    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign err  = err_q;

    onehot_dec #(
        .N (NUM_REGS),
        .W (IDX_W)
    ) u_dec_out (
        .en     (rs_en),
        .idx    (rs_sel),
        .onehot (reg_out)
    );

    onehot_dec #(
        .N (NUM_REGS),
        .W (IDX_W)
    ) u_dec_in (
        .en     (wr_en),
        .idx    (rd_q),
        .onehot (reg_in)
    );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: directed literal cases plus
// randomized traffic against a cycle-offset reference model.
module tb_alu_step_sequencer;

    localparam int NR = 12;
    localparam int WM = 4;

    localparam int P_IDLE = 0;
    localparam int P_A    = 1;
    localparam int P_X    = 2;
    localparam int P_W    = 3;
    localparam int P_L    = 4;
    localparam int P_H    = 5;

    localparam logic [4:0] ADD = 5'b00011;
    localparam logic [4:0] SUB = 5'b00100;
    localparam logic [4:0] SHR = 5'b00101;
    localparam logic [4:0] MUL = 5'b01111;
    localparam logic [4:0] DIV = 5'b10000;
    localparam logic [4:0] NOT = 5'b10010;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic [NR-1:0] reg_out;
        logic [NR-1:0] reg_in;
        logic          ry_in;
        logic          ry_out;
        logic          rz_in;
        logic          rzlo;
        logic          rzhi;
        logic          hi_in;
        logic          lo_in;
        logic [4:0]    alu_op;
    } out_t;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [4:0]    op;
    logic [3:0]    ra_idx;
    logic [3:0]    rb_idx;
    logic [3:0]    rd_idx;
    logic          alu_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [NR-1:0] reg_out;
    logic [NR-1:0] reg_in;
    logic          ry_in;
    logic          ry_out;
    logic          rz_in;
    logic          rzlo_out;
    logic          rzhi_out;
    logic          hi_in;
    logic          lo_in;
    logic [4:0]    alu_op;

    int  checks = 0;
    int  fails  = 0;
    bit  chk_en = 1'b0;

    // model: instruction kind 0=binary 1=unary 2=mul/div
    bit         m_act  = 1'b0;
    bit         m_err  = 1'b0;
    int         m_kind = 0;
    int         m_t    = 0;
    int         m_w    = 0;
    int         m_post = 0;
    logic [4:0] m_op   = '0;
    int         m_ra   = 0;
    int         m_rb   = 0;
    int         m_rd   = 0;

    logic [4:0] vops [13] = '{
        5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
        5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18
    };

    alu_step_sequencer #(
        .NUM_REGS (NR),
        .IDX_W    (4),
        .OP_W     (5),
        .WAIT_MAX (WM)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .op        (op),
        .ra_idx    (ra_idx),
        .rb_idx    (rb_idx),
        .rd_idx    (rd_idx),
        .alu_ready (alu_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .reg_out   (reg_out),
        .reg_in    (reg_in),
        .ry_in     (ry_in),
        .ry_out    (ry_out),
        .rz_in     (rz_in),
        .rzlo_out  (rzlo_out),
        .rzhi_out  (rzhi_out),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .alu_op    (alu_op)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [4:0] o, input int a,
                                 input int b, input int d);
        bit ok;
        ok = 1'b0;
        foreach (vops[i]) if (vops[i] == o) ok = 1'b1;
        return ok && a < NR && b < NR && d < NR;
    endfunction

    // Where in its instruction the model is, by cycle offset.
    function automatic int phase_of();
        if (!m_act) return P_IDLE;
        if (m_kind == 1) return (m_t == 1) ? P_X : P_L;
        if (m_t == 1) return P_A;
        if (m_t == 2) return P_X;
        if (m_kind == 0) return P_L;
        if (m_post == 0) return P_W;
        return (m_post == 1) ? P_L : P_H;
    endfunction

    function automatic out_t model_out();
        out_t e;
        int   p;
        bit   md;
        e  = '0;
        p  = phase_of();
        md = (m_kind == 2);
        e.busy = (p != P_IDLE);
        e.err  = m_err;
        case (p)
            P_A: begin
                e.reg_out = NR'(1) << m_ra;
                e.ry_in   = 1'b1;
            end
            P_X, P_W: begin
                e.reg_out = NR'(1) << m_rb;
                e.ry_out  = 1'b1;
                e.alu_op  = m_op;
                e.rz_in   = (p == P_X) ? !md : alu_ready;
            end
            P_L: begin
                e.rzlo  = 1'b1;
                e.lo_in = md;
                e.done  = !md;
                if (!md) e.reg_in = NR'(1) << m_rd;
            end
            P_H: begin
                e.rzhi  = 1'b1;
                e.hi_in = 1'b1;
                e.done  = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clock) begin : mdl
        int p;
        p = phase_of();
        if (!clear) begin
            m_act = 1'b0;
            m_err = 1'b0;
        end else if (!m_act) begin
            m_err = 1'b0;
            if (start) begin
                if (!legal(op, ra_idx, rb_idx, rd_idx)) begin
                    m_err = 1'b1;
                end else begin
                    m_act  = 1'b1;
                    m_op   = op;
                    m_ra   = ra_idx;
                    m_rb   = rb_idx;
                    m_rd   = rd_idx;
                    m_t    = 1;
                    m_w    = 0;
                    m_post = 0;
                    if (op == 5'd17 || op == 5'd18) m_kind = 1;
                    else if (op == 5'd15 || op == 5'd16) m_kind = 2;
                    else m_kind = 0;
                end
            end
        end else begin
            m_err = 1'b0;
            case (p)
                P_A, P_X: m_t++;
                P_W: begin
                    m_w++;
                    if (alu_ready) m_post = 1;
                    else if (m_w == WM) begin
                        m_act = 1'b0;
                        m_err = 1'b1;
                    end
                end
                P_L: begin
                    if (m_kind == 2) m_post = 2;
                    else m_act = 1'b0;
                end
                default: m_act = 1'b0;
            endcase
        end
    end

    always @(negedge clock) begin
        out_t e;
        out_t a;
        if (chk_en) begin
            e = model_out();
            a = {busy, done, err, reg_out, reg_in, ry_in, ry_out,
                 rz_in, rzlo_out, rzhi_out, hi_in, lo_in, alu_op};
            chk("busy", 32'(a.busy), 32'(e.busy));
            chk("done", 32'(a.done), 32'(e.done));
            chk("err", 32'(a.err), 32'(e.err));
            chk("reg_out", 32'(a.reg_out), 32'(e.reg_out));
            chk("reg_in", 32'(a.reg_in), 32'(e.reg_in));
            chk("strobes", {25'd0, a.ry_in, a.ry_out, a.rz_in,
                            a.rzlo, a.rzhi, a.hi_in, a.lo_in},
                           {25'd0, e.ry_in, e.ry_out, e.rz_in,
                            e.rzlo, e.rzhi, e.hi_in, e.lo_in});
            chk("alu_op", 32'(a.alu_op), 32'(e.alu_op));
            chk("reg_out_onehot", 32'($countones(reg_out) <= 1), 32'd1);
            chk("one_bus_driver",
                32'(($countones(reg_out) + 32'(rzlo_out)
                     + 32'(rzhi_out)) <= 1), 32'd1);
        end
    end

    task automatic nxt();
        @(posedge clock);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic launch(input logic [4:0] o, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] d);
        start  = 1'b1;
        op     = o;
        ra_idx = a;
        rb_idx = b;
        rd_idx = d;
        nxt();
        start = 1'b0;
    endtask

    initial begin
        clear     = 1'b0;
        start     = 1'b0;
        op        = '0;
        ra_idx    = '0;
        rb_idx    = '0;
        rd_idx    = '0;
        alu_ready = 1'b0;
        nxt();
        nxt();
        chk_en = 1'b1;
        clear  = 1'b1;
        at_neg();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_reg_out", 32'(reg_out), 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd0);

        // binary SHR
        nxt();
        launch(SHR, 4'd1, 4'd2, 4'd5);
        at_neg();
        chk("shr_k1_reg_out", 32'(reg_out), 32'h002);
        chk("shr_k1_ry_in", 32'(ry_in), 32'd1);
        chk("model_k1_ry_in", 32'(model_out().ry_in), 32'd1);
        nxt();
        at_neg();
        chk("shr_k2_reg_out", 32'(reg_out), 32'h004);
        chk("shr_k2_rz_in", 32'(rz_in & ry_out), 32'd1);
        chk("shr_k2_alu_op", 32'(alu_op), 32'h05);
        nxt();
        at_neg();
        chk("shr_k3_reg_in", 32'(reg_in), 32'h020);
        chk("shr_k3_done", 32'(done & rzlo_out), 32'd1);
        chk("model_k3_reg_in", 32'(model_out().reg_in), 32'h020);
        nxt();
        at_neg();
        chk("shr_k4_busy", 32'(busy), 32'd0);

        // MUL with ready in the third WAIT cycle
        nxt();
        launch(MUL, 4'd3, 4'd4, 4'd6);
        nxt();
        at_neg();
        chk("mul_k2_rz_in", 32'(rz_in), 32'd0);
        chk("mul_k2_alu_op", 32'(alu_op), 32'(MUL));
        nxt();
        at_neg();
        chk("mul_k3_rz_in", 32'(rz_in), 32'd0);
        nxt();
        nxt();
        alu_ready = 1'b1;
        at_neg();
        chk("mul_k5_rz_in", 32'(rz_in), 32'd1);
        nxt();
        alu_ready = 1'b0;
        at_neg();
        chk("mul_k6_lo_in", 32'(lo_in), 32'd1);
        chk("mul_k6_done", 32'(done), 32'd0);
        nxt();
        at_neg();
        chk("mul_k7_hi_done", 32'(hi_in & done & rzhi_out), 32'd1);
        chk("mul_k7_reg_in", 32'(reg_in), 32'd0);
        nxt();
        at_neg();
        chk("mul_k8_busy", 32'(busy), 32'd0);

        // DIV timeout
        nxt();
        launch(DIV, 4'd1, 4'd2, 4'd3);
        repeat (5) nxt();
        at_neg();
        chk("div_k6_busy", 32'(busy), 32'd1);
        chk("div_k6_err", 32'(err), 32'd0);
        nxt();
        at_neg();
        chk("div_k7_err", 32'(err), 32'd1);
        chk("div_k7_busy", 32'(busy), 32'd0);
        chk("div_k7_hi_lo", 32'({hi_in, lo_in}), 32'd0);
        nxt();
        at_neg();
        chk("div_k8_err", 32'(err), 32'd0);

        // unary NOT, rd == rb
        nxt();
        launch(NOT, 4'd0, 4'd3, 4'd3);
        at_neg();
        chk("not_k1_reg_out", 32'(reg_out), 32'h008);
        chk("not_k1_ry_in", 32'(ry_in), 32'd0);
        chk("not_k1_alu_op", 32'(alu_op), 32'(NOT));
        nxt();
        at_neg();
        chk("not_k2_done", 32'(done), 32'd1);
        chk("not_k2_reg_in", 32'(reg_in), 32'h008);
        nxt();
        at_neg();
        chk("not_k3_busy", 32'(busy), 32'd0);

        // illegal opcode, then out-of-range index
        nxt();
        launch(5'b11111, 4'd0, 4'd1, 4'd2);
        at_neg();
        chk("badop_err", 32'(err), 32'd1);
        chk("badop_busy", 32'(busy), 32'd0);
        nxt();
        at_neg();
        chk("badop_err_clr", 32'(err), 32'd0);
        nxt();
        launch(ADD, 4'd0, 4'd1, 4'd13);
        at_neg();
        chk("badidx_err", 32'(err), 32'd1);
        chk("badidx_busy", 32'(busy), 32'd0);

        // reset during EXEC, with an ignored start while busy
        nxt();
        launch(ADD, 4'd1, 4'd2, 4'd3);
        start  = 1'b1;
        op     = SUB;
        rb_idx = 4'd7;
        nxt();
        start = 1'b0;
        at_neg();
        chk("rst_exec_alu_op", 32'(alu_op), 32'(ADD));
        chk("rst_exec_reg_out", 32'(reg_out), 32'h004);
        clear = 1'b0;
        nxt();
        clear = 1'b1;
        at_neg();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reg_in", 32'(reg_in), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // back-to-back with start held high
        nxt();
        start  = 1'b1;
        op     = ADD;
        ra_idx = 4'd2;
        rb_idx = 4'd5;
        rd_idx = 4'd9;
        nxt();
        at_neg();
        chk("b2b_k1_ry_in", 32'(ry_in), 32'd1);
        nxt();
        nxt();
        at_neg();
        chk("b2b_k3_done", 32'(done), 32'd1);
        nxt();
        at_neg();
        chk("b2b_k4_busy", 32'(busy), 32'd0);
        nxt();
        at_neg();
        chk("b2b_k5_ry_in", 32'(ry_in & busy), 32'd1);
        nxt();
        start = 1'b0;
        repeat (4) nxt();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 2) == 0);
            alu_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) op = 5'($urandom());
            else op = vops[$urandom_range(0, 12)];
            ra_idx = 4'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : NR - 1));
            rb_idx = 4'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : NR - 1));
            rd_idx = 4'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : NR - 1));
            nxt();
        end
        start = 1'b0;
        clear = 1'b1;
        repeat (12) nxt();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
